// File: rtl/alu_rs_scheduler.sv
// Reservation station for the single ALU: holds dispatched ops until both
// operands are known (via CDB snooping) and issues the lowest-index ready op.
module alu_rs_scheduler #(
  parameter int RS_BIT  = 3,
  parameter int OP_W    = 6,
  parameter int ROB_BIT = 4,
  parameter int DAT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               flush_i,
  input  logic               dsp_en_i,
  input  logic [OP_W-1:0]    dsp_op_i,
  input  logic               dsp_ic_i,
  input  logic [ROB_BIT-1:0] dsp_qd_i,
  input  logic               dsp_rs_rdy_i,
  input  logic [ROB_BIT-1:0] dsp_qs_i,
  input  logic [DAT_W-1:0]   dsp_vs_i,
  input  logic               dsp_rt_rdy_i,
  input  logic [ROB_BIT-1:0] dsp_qt_i,
  input  logic [DAT_W-1:0]   dsp_vt_i,
  input  logic [DAT_W-1:0]   dsp_imm_i,
  input  logic [DAT_W-1:0]   dsp_pc_i,
  output logic               full_o,
  input  logic               cdb_alu_en_i,
  input  logic [ROB_BIT-1:0] cdb_alu_q_i,
  input  logic [DAT_W-1:0]   cdb_alu_v_i,
  input  logic               cdb_lsb_en_i,
  input  logic [ROB_BIT-1:0] cdb_lsb_q_i,
  input  logic [DAT_W-1:0]   cdb_lsb_v_i,
  output logic               alu_en_o,
  output logic [OP_W-1:0]    alu_op_o,
  output logic               alu_ic_o,
  output logic [ROB_BIT-1:0] alu_qd_o,
  output logic [DAT_W-1:0]   alu_vs_o,
  output logic [DAT_W-1:0]   alu_vt_o,
  output logic [DAT_W-1:0]   alu_imm_o,
  output logic [DAT_W-1:0]   alu_pc_o
);

  localparam int RS_SIZE = 1 << RS_BIT;

  logic [RS_SIZE-1:0] busy_r;
  logic [RS_SIZE-1:0] ic_r;
  logic [RS_SIZE-1:0] rs_rdy_r;
  logic [RS_SIZE-1:0] rt_rdy_r;
  logic [OP_W-1:0]    op_r  [RS_SIZE];
  logic [ROB_BIT-1:0] qd_r  [RS_SIZE];
  logic [ROB_BIT-1:0] qs_r  [RS_SIZE];
  logic [ROB_BIT-1:0] qt_r  [RS_SIZE];
  logic [DAT_W-1:0]   vs_r  [RS_SIZE];
  logic [DAT_W-1:0]   vt_r  [RS_SIZE];
  logic [DAT_W-1:0]   imm_r [RS_SIZE];
  logic [DAT_W-1:0]   pc_r  [RS_SIZE];

  logic [RS_SIZE-1:0] ready_s;
  logic               full_s;
  logic               sel_vld_s;
  logic [RS_BIT-1:0]  free_idx_s;
  logic [RS_BIT-1:0]  sel_idx_s;
  logic               dsp_rs_rdy_s;
  logic               dsp_rt_rdy_s;
  logic [DAT_W-1:0]   dsp_vs_s;
  logic [DAT_W-1:0]   dsp_vt_s;

  function automatic logic tag_hit(input logic bus_en, input logic [ROB_BIT-1:0] bus_q,
                                   input logic [ROB_BIT-1:0] tag);
    return bus_en && (bus_q == tag);
  endfunction

  assign full_o = full_s;

  // Priority pickers: lowest free slot for dispatch, lowest ready slot for issue
  always_comb begin
    ready_s    = busy_r & rs_rdy_r & rt_rdy_r;
    full_s     = &busy_r;
    sel_vld_s  = |ready_s;
    free_idx_s = '0;
    sel_idx_s  = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      free_idx_s = busy_r[i]  ? free_idx_s : RS_BIT'(i);
      sel_idx_s  = ready_s[i] ? RS_BIT'(i) : sel_idx_s;
    end
  end

  // Dispatch-time operand forwarding; the ALU bus takes precedence over the LSB bus
  always_comb begin
    if (dsp_rs_rdy_i) begin
      dsp_rs_rdy_s = 1'b1;
      dsp_vs_s     = dsp_vs_i;
    end else if (tag_hit(cdb_alu_en_i, cdb_alu_q_i, dsp_qs_i)) begin
      dsp_rs_rdy_s = 1'b1;
      dsp_vs_s     = cdb_alu_v_i;
    end else if (tag_hit(cdb_lsb_en_i, cdb_lsb_q_i, dsp_qs_i)) begin
      dsp_rs_rdy_s = 1'b1;
      dsp_vs_s     = cdb_lsb_v_i;
    end else begin
      dsp_rs_rdy_s = 1'b0;
      dsp_vs_s     = dsp_vs_i;
    end
    if (dsp_rt_rdy_i) begin
      dsp_rt_rdy_s = 1'b1;
      dsp_vt_s     = dsp_vt_i;
    end else if (tag_hit(cdb_alu_en_i, cdb_alu_q_i, dsp_qt_i)) begin
      dsp_rt_rdy_s = 1'b1;
      dsp_vt_s     = cdb_alu_v_i;
    end else if (tag_hit(cdb_lsb_en_i, cdb_lsb_q_i, dsp_qt_i)) begin
      dsp_rt_rdy_s = 1'b1;
      dsp_vt_s     = cdb_lsb_v_i;
    end else begin
      dsp_rt_rdy_s = 1'b0;
      dsp_vt_s     = dsp_vt_i;
    end
  end

  // Entry storage, CDB wakeup, dispatch write and registered issue
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r    <= '0;
      ic_r      <= '0;
      rs_rdy_r  <= '0;
      rt_rdy_r  <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        op_r[i]  <= '0;
        qd_r[i]  <= '0;
        qs_r[i]  <= '0;
        qt_r[i]  <= '0;
        vs_r[i]  <= '0;
        vt_r[i]  <= '0;
        imm_r[i] <= '0;
        pc_r[i]  <= '0;
      end
      alu_en_o  <= 1'b0;
      alu_op_o  <= '0;
      alu_ic_o  <= 1'b0;
      alu_qd_o  <= '0;
      alu_vs_o  <= '0;
      alu_vt_o  <= '0;
      alu_imm_o <= '0;
      alu_pc_o  <= '0;
    end else if (en) begin
      if (flush_i) begin
        busy_r   <= '0;
        alu_en_o <= 1'b0;
      end else begin
        // Free slots are never woken, so wakeup and dispatch never touch the same entry
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy_r[i] && !rs_rdy_r[i]) begin
            if (tag_hit(cdb_alu_en_i, cdb_alu_q_i, qs_r[i])) begin
              vs_r[i]     <= cdb_alu_v_i;
              rs_rdy_r[i] <= 1'b1;
            end else if (tag_hit(cdb_lsb_en_i, cdb_lsb_q_i, qs_r[i])) begin
              vs_r[i]     <= cdb_lsb_v_i;
              rs_rdy_r[i] <= 1'b1;
            end
          end
          if (busy_r[i] && !rt_rdy_r[i]) begin
            if (tag_hit(cdb_alu_en_i, cdb_alu_q_i, qt_r[i])) begin
              vt_r[i]     <= cdb_alu_v_i;
              rt_rdy_r[i] <= 1'b1;
            end else if (tag_hit(cdb_lsb_en_i, cdb_lsb_q_i, qt_r[i])) begin
              vt_r[i]     <= cdb_lsb_v_i;
              rt_rdy_r[i] <= 1'b1;
            end
          end
        end
        if (dsp_en_i && !full_s) begin
          busy_r[free_idx_s]   <= 1'b1;
          op_r[free_idx_s]     <= dsp_op_i;
          ic_r[free_idx_s]     <= dsp_ic_i;
          qd_r[free_idx_s]     <= dsp_qd_i;
          qs_r[free_idx_s]     <= dsp_qs_i;
          qt_r[free_idx_s]     <= dsp_qt_i;
          rs_rdy_r[free_idx_s] <= dsp_rs_rdy_s;
          rt_rdy_r[free_idx_s] <= dsp_rt_rdy_s;
          vs_r[free_idx_s]     <= dsp_vs_s;
          vt_r[free_idx_s]     <= dsp_vt_s;
          imm_r[free_idx_s]    <= dsp_imm_i;
          pc_r[free_idx_s]     <= dsp_pc_i;
        end
        if (sel_vld_s) begin
          busy_r[sel_idx_s] <= 1'b0;
          alu_en_o          <= 1'b1;
          alu_op_o          <= op_r[sel_idx_s];
          alu_ic_o          <= ic_r[sel_idx_s];
          alu_qd_o          <= qd_r[sel_idx_s];
          alu_vs_o          <= vs_r[sel_idx_s];
          alu_vt_o          <= vt_r[sel_idx_s];
          alu_imm_o         <= imm_r[sel_idx_s];
          alu_pc_o          <= pc_r[sel_idx_s];
        end else begin
          alu_en_o <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Directed bench for alu_rs_scheduler: a queue-style entry model checked every
// cycle, plus hand-computed expectations at key points of each scenario.
module tb_alu_rs_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        flush_i = 1'b0;
  logic        dsp_en_i = 1'b0;
  logic [5:0]  dsp_op_i = '0;
  logic        dsp_ic_i = 1'b0;
  logic [3:0]  dsp_qd_i = '0;
  logic        dsp_rs_rdy_i = 1'b0;
  logic [3:0]  dsp_qs_i = '0;
  logic [31:0] dsp_vs_i = '0;
  logic        dsp_rt_rdy_i = 1'b0;
  logic [3:0]  dsp_qt_i = '0;
  logic [31:0] dsp_vt_i = '0;
  logic [31:0] dsp_imm_i = '0;
  logic [31:0] dsp_pc_i = '0;
  logic        cdb_alu_en_i = 1'b0;
  logic [3:0]  cdb_alu_q_i = '0;
  logic [31:0] cdb_alu_v_i = '0;
  logic        cdb_lsb_en_i = 1'b0;
  logic [3:0]  cdb_lsb_q_i = '0;
  logic [31:0] cdb_lsb_v_i = '0;
  logic        full_o, alu_en_o, alu_ic_o;
  logic [5:0]  alu_op_o;
  logic [3:0]  alu_qd_o;
  logic [31:0] alu_vs_o, alu_vt_o, alu_imm_o, alu_pc_o;

  alu_rs_scheduler dut (
    .clk(clk), .rst(rst), .en(en), .flush_i(flush_i),
    .dsp_en_i(dsp_en_i), .dsp_op_i(dsp_op_i), .dsp_ic_i(dsp_ic_i), .dsp_qd_i(dsp_qd_i),
    .dsp_rs_rdy_i(dsp_rs_rdy_i), .dsp_qs_i(dsp_qs_i), .dsp_vs_i(dsp_vs_i),
    .dsp_rt_rdy_i(dsp_rt_rdy_i), .dsp_qt_i(dsp_qt_i), .dsp_vt_i(dsp_vt_i),
    .dsp_imm_i(dsp_imm_i), .dsp_pc_i(dsp_pc_i), .full_o(full_o),
    .cdb_alu_en_i(cdb_alu_en_i), .cdb_alu_q_i(cdb_alu_q_i), .cdb_alu_v_i(cdb_alu_v_i),
    .cdb_lsb_en_i(cdb_lsb_en_i), .cdb_lsb_q_i(cdb_lsb_q_i), .cdb_lsb_v_i(cdb_lsb_v_i),
    .alu_en_o(alu_en_o), .alu_op_o(alu_op_o), .alu_ic_o(alu_ic_o), .alu_qd_o(alu_qd_o),
    .alu_vs_o(alu_vs_o), .alu_vt_o(alu_vt_o), .alu_imm_o(alu_imm_o), .alu_pc_o(alu_pc_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        busy;
    logic [5:0]  op;
    logic        ic;
    logic [3:0]  qd;
    logic        rs_rdy;
    logic [3:0]  qs;
    logic [31:0] vs;
    logic        rt_rdy;
    logic [3:0]  qt;
    logic [31:0] vt;
    logic [31:0] imm;
    logic [31:0] pc;
  } ent_t;

  ent_t        m_ent [8];
  logic        m_en, m_ic;
  logic [5:0]  m_op;
  logic [3:0]  m_qd;
  logic [31:0] m_vs, m_vt, m_imm, m_pc;

  // Operand value as seen after this edge's broadcasts (ALU bus preferred)
  function automatic logic [32:0] resolve(input logic rdy, input logic [3:0] tag,
                                          input logic [31:0] val);
    if (rdy) return {1'b1, val};
    if (cdb_alu_en_i && cdb_alu_q_i == tag) return {1'b1, cdb_alu_v_i};
    if (cdb_lsb_en_i && cdb_lsb_q_i == tag) return {1'b1, cdb_lsb_v_i};
    return {1'b0, val};
  endfunction

  function automatic logic m_full();
    for (int i = 0; i < 8; i++) if (!m_ent[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    ent_t old [8];
    int pick;
    int slot;
    logic [32:0] r;
    if (!rst) begin
      for (int i = 0; i < 8; i++) m_ent[i] = '0;
      {m_en, m_ic, m_op, m_qd, m_vs, m_vt, m_imm, m_pc} = '0;
      return;
    end
    if (!en) return;
    if (flush_i) begin
      for (int i = 0; i < 8; i++) m_ent[i].busy = 1'b0;
      m_en = 1'b0;
      return;
    end
    old = m_ent;
    pick = -1;
    slot = -1;
    for (int i = 0; i < 8; i++) begin
      if (pick < 0 && old[i].busy && old[i].rs_rdy && old[i].rt_rdy) pick = i;
      if (slot < 0 && !old[i].busy) slot = i;
    end
    for (int i = 0; i < 8; i++) begin
      if (old[i].busy) begin
        r = resolve(old[i].rs_rdy, old[i].qs, old[i].vs);
        m_ent[i].rs_rdy = r[32];
        m_ent[i].vs     = r[31:0];
        r = resolve(old[i].rt_rdy, old[i].qt, old[i].vt);
        m_ent[i].rt_rdy = r[32];
        m_ent[i].vt     = r[31:0];
      end
    end
    if (dsp_en_i && slot >= 0) begin
      m_ent[slot].busy = 1'b1;
      m_ent[slot].op   = dsp_op_i;
      m_ent[slot].ic   = dsp_ic_i;
      m_ent[slot].qd   = dsp_qd_i;
      m_ent[slot].qs   = dsp_qs_i;
      m_ent[slot].qt   = dsp_qt_i;
      m_ent[slot].imm  = dsp_imm_i;
      m_ent[slot].pc   = dsp_pc_i;
      r = resolve(dsp_rs_rdy_i, dsp_qs_i, dsp_vs_i);
      m_ent[slot].rs_rdy = r[32];
      m_ent[slot].vs     = r[31:0];
      r = resolve(dsp_rt_rdy_i, dsp_qt_i, dsp_vt_i);
      m_ent[slot].rt_rdy = r[32];
      m_ent[slot].vt     = r[31:0];
    end
    if (pick >= 0) begin
      m_en  = 1'b1;
      m_op  = old[pick].op;
      m_ic  = old[pick].ic;
      m_qd  = old[pick].qd;
      m_vs  = old[pick].vs;
      m_vt  = old[pick].vt;
      m_imm = old[pick].imm;
      m_pc  = old[pick].pc;
      m_ent[pick].busy = 1'b0;
    end else begin
      m_en = 1'b0;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst);
    model_step();
  end

  // Per-cycle comparison against the model, mid-period
  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      chk("cyc_en",   alu_en_o,  m_en);
      chk("cyc_op",   alu_op_o,  m_op);
      chk("cyc_ic",   alu_ic_o,  m_ic);
      chk("cyc_qd",   alu_qd_o,  m_qd);
      chk("cyc_vs",   alu_vs_o,  m_vs);
      chk("cyc_vt",   alu_vt_o,  m_vt);
      chk("cyc_imm",  alu_imm_o, m_imm);
      chk("cyc_pc",   alu_pc_o,  m_pc);
      chk("cyc_full", full_o,    m_full());
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dsp_en_i = 1'b0;
    cdb_alu_en_i = 1'b0;
    cdb_lsb_en_i = 1'b0;
    flush_i = 1'b0;
  endtask

  task automatic dsp(input logic [5:0] op, input logic [3:0] qd,
                     input logic rr, input logic [3:0] qs, input logic [31:0] vs,
                     input logic tr, input logic [3:0] qt, input logic [31:0] vt,
                     input logic [31:0] imm);
    dsp_en_i = 1'b1;
    dsp_op_i = op;
    dsp_ic_i = qd[0];
    dsp_qd_i = qd;
    dsp_rs_rdy_i = rr;
    dsp_qs_i = qs;
    dsp_vs_i = vs;
    dsp_rt_rdy_i = tr;
    dsp_qt_i = qt;
    dsp_vt_i = vt;
    dsp_imm_i = imm;
    dsp_pc_i = 32'h0000_1000 + {26'd0, qd, 2'b00};
  endtask

  task automatic alu_bus(input logic [3:0] q, input logic [31:0] v);
    cdb_alu_en_i = 1'b1;
    cdb_alu_q_i = q;
    cdb_alu_v_i = v;
  endtask

  task automatic lsb_bus(input logic [3:0] q, input logic [31:0] v);
    cdb_lsb_en_i = 1'b1;
    cdb_lsb_q_i = q;
    cdb_lsb_v_i = v;
  endtask

  initial begin
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    chk_on = 1'b1;
    chk("rst_en", alu_en_o, 1'b0);
    chk("rst_full", full_o, 1'b0);
    chk("rst_vs", alu_vs_o, 32'h0);

    // Ready dispatch: 2-edge latency, single issue
    dsp(6'h13, 4'h5, 1'b1, 4'h0, 32'd5, 1'b1, 4'h0, 32'd0, 32'd7);
    cyc(); idle();
    chk("rdy_e1_en", alu_en_o, 1'b0);
    cyc();
    chk("rdy_e2_en", alu_en_o, 1'b1);
    chk("rdy_e2_vs", alu_vs_o, 32'd5);
    chk("rdy_e2_imm", alu_imm_o, 32'd7);
    chk("rdy_e2_qd", alu_qd_o, 32'h5);
    chk("rdy_e2_pc", alu_pc_o, 32'h0000_1014);
    cyc();
    chk("rdy_e3_en", alu_en_o, 1'b0);
    chk("rdy_e3_vs_hold", alu_vs_o, 32'd5);

    // Wakeup from LSB bus, no same-edge wake-to-issue
    dsp(6'h01, 4'h1, 1'b0, 4'h3, 32'd0, 1'b1, 4'h0, 32'd2, 32'd0);
    cyc(); idle();
    cyc();
    chk("wk_wait_en", alu_en_o, 1'b0);
    lsb_bus(4'h3, 32'h10);
    cyc(); idle();
    chk("wk_edge_en", alu_en_o, 1'b0);
    cyc();
    chk("wk_iss_en", alu_en_o, 1'b1);
    chk("wk_iss_vs", alu_vs_o, 32'h10);
    chk("wk_iss_vt", alu_vt_o, 32'd2);
    chk("wk_iss_qd", alu_qd_o, 32'h1);

    // Dispatch-time forwarding
    dsp(6'h01, 4'h2, 1'b0, 4'h3, 32'd0, 1'b1, 4'h0, 32'd2, 32'd0);
    lsb_bus(4'h3, 32'h20);
    cyc(); idle();
    chk("fwd_d_en", alu_en_o, 1'b0);
    cyc();
    chk("fwd_en", alu_en_o, 1'b1);
    chk("fwd_vs", alu_vs_o, 32'h20);

    // Both buses match at dispatch: ALU value wins
    dsp(6'h01, 4'h4, 1'b0, 4'h4, 32'd0, 1'b1, 4'h0, 32'd0, 32'd0);
    alu_bus(4'h4, 32'hAA);
    lsb_bus(4'h4, 32'hBB);
    cyc(); idle();
    cyc();
    chk("prio_vs", alu_vs_o, 32'hAA);
    chk("prio_qd", alu_qd_o, 32'h4);

    // Dual bus waking both operands of one entry
    dsp(6'h01, 4'h3, 1'b0, 4'h2, 32'd0, 1'b0, 4'h6, 32'd0, 32'd0);
    cyc(); idle();
    alu_bus(4'h2, 32'd1);
    lsb_bus(4'h6, 32'd9);
    cyc(); idle();
    cyc();
    chk("dual_en", alu_en_o, 1'b1);
    chk("dual_vs", alu_vs_o, 32'd1);
    chk("dual_vt", alu_vt_o, 32'd9);
    cyc();

    // Fill all 8 entries, drop a 9th, lowest-index priority on wake
    for (int i = 0; i < 8; i++) begin
      dsp(6'h02, 4'(i), 1'b0, 4'(8 + i), 32'd0, 1'b1, 4'h0, 32'(i), 32'd0);
      cyc();
    end
    idle();
    chk("full_set", full_o, 1'b1);
    dsp(6'h03, 4'h9, 1'b1, 4'h0, 32'h33, 1'b1, 4'h0, 32'd0, 32'd0);
    cyc(); idle();
    chk("full_drop_full", full_o, 1'b1);
    cyc();
    chk("full_drop_en", alu_en_o, 1'b0);
    alu_bus(4'hA, 32'h22);
    lsb_bus(4'hD, 32'h55);
    cyc(); idle();
    chk("full_wk_en", alu_en_o, 1'b0);
    cyc();
    chk("full_i2_en", alu_en_o, 1'b1);
    chk("full_i2_qd", alu_qd_o, 32'h2);
    chk("full_i2_vs", alu_vs_o, 32'h22);
    chk("full_i2_full", full_o, 1'b0);
    cyc();
    chk("full_i5_en", alu_en_o, 1'b1);
    chk("full_i5_qd", alu_qd_o, 32'h5);
    chk("full_i5_vs", alu_vs_o, 32'h55);
    cyc();
    chk("full_end_en", alu_en_o, 1'b0);

    // Flush with busy entries, a pending ready issue and a same-cycle dispatch
    flush_i = 1'b1;
    cyc(); idle();
    chk("fl0_full", full_o, 1'b0);
    for (int i = 0; i < 4; i++) begin
      dsp(6'h02, 4'(i), 1'b0, 4'h1, 32'd0, 1'b1, 4'h0, 32'd0, 32'd0);
      cyc();
    end
    dsp(6'h05, 4'hE, 1'b1, 4'h0, 32'h44, 1'b1, 4'h0, 32'd0, 32'd0);
    cyc(); idle();
    flush_i = 1'b1;
    dsp(6'h06, 4'hF, 1'b1, 4'h0, 32'h45, 1'b1, 4'h0, 32'd0, 32'd0);
    cyc(); idle();
    chk("fl_en", alu_en_o, 1'b0);
    chk("fl_full", full_o, 1'b0);
    cyc();
    chk("fl_lost_en", alu_en_o, 1'b0);
    alu_bus(4'h1, 32'd5);
    cyc(); idle();
    cyc();
    chk("fl_nowk_en", alu_en_o, 1'b0);

    // en=0: no capture from a matching broadcast, outputs frozen
    dsp(6'h02, 4'h7, 1'b0, 4'h5, 32'd0, 1'b1, 4'h0, 32'd0, 32'd0);
    cyc(); idle();
    en = 1'b0;
    alu_bus(4'h5, 32'h77);
    cyc(); cyc();
    en = 1'b1;
    idle();
    cyc(); cyc();
    chk("en0_nocap", alu_en_o, 1'b0);
    alu_bus(4'h5, 32'h99);
    cyc(); idle();
    cyc();
    chk("en1_en", alu_en_o, 1'b1);
    chk("en1_vs", alu_vs_o, 32'h99);
    en = 1'b0;
    cyc(); cyc();
    chk("en0_hold_en", alu_en_o, 1'b1);
    chk("en0_hold_vs", alu_vs_o, 32'h99);
    en = 1'b1;
    cyc();
    chk("en_rel_en", alu_en_o, 1'b0);

    // Asynchronous reset mid-run with 3 busy entries and a live issue
    for (int i = 0; i < 3; i++) begin
      dsp(6'h02, 4'(i), 1'b0, 4'h2, 32'd0, 1'b1, 4'h0, 32'd0, 32'd0);
      cyc();
    end
    dsp(6'h01, 4'hC, 1'b1, 4'h0, 32'h66, 1'b1, 4'h0, 32'd0, 32'd0);
    cyc(); idle();
    cyc();
    chk("rr_pre_en", alu_en_o, 1'b1);
    chk("rr_pre_vs", alu_vs_o, 32'h66);
    chk("rr_pre_full", full_o, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("rr_en", alu_en_o, 1'b0);
    chk("rr_vs", alu_vs_o, 32'h0);
    chk("rr_full", full_o, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    alu_bus(4'h2, 32'd3);
    cyc(); idle();
    cyc();
    chk("rr_post_en", alu_en_o, 1'b0);
    chk("rr_post_full", full_o, 1'b0);

    cyc(); cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_rs_scheduler.md
Name: alu_rs_scheduler

Overview:
Reservation station and issue scheduler for the single ALU. Accepts decoded ALU and branch ops from dispatch and holds them until both source operands are known. Operands are woken up by snooping the ALU and LSB result buses. Each cycle it selects one ready entry and presents it, registered, on the ALU's rs_* input bundle.

Parameters:
RS_BIT, 3, log2 of entry count (RS_SIZE = 2^RS_BIT = 8)
OP_W, 6, opcode width
ROB_BIT, 4, ROB tag width
DAT_W, 32, data width

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
en  in  1  global ready; low freezes all state and outputs
flush_i  in  1  misprediction clear
dsp_en_i  in  1  dispatch valid
dsp_op_i  in  OP_W  opcode
dsp_ic_i  in  1  compressed-instruction flag
dsp_qd_i  in  ROB_BIT  destination ROB tag
dsp_rs_rdy_i  in  1  1 = dsp_vs_i valid
dsp_qs_i  in  ROB_BIT  producer tag of vs
dsp_vs_i  in  DAT_W  source value 1
dsp_rt_rdy_i  in  1  1 = dsp_vt_i valid
dsp_qt_i  in  ROB_BIT  producer tag of vt
dsp_vt_i  in  DAT_W  source value 2
dsp_imm_i  in  DAT_W  immediate
dsp_pc_i  in  DAT_W  instruction PC
full_o  out  1  no free entry
cdb_alu_en_i  in  1  ALU result broadcast valid
cdb_alu_q_i  in  ROB_BIT  ALU result tag
cdb_alu_v_i  in  DAT_W  ALU result value
cdb_lsb_en_i  in  1  LSB result broadcast valid
cdb_lsb_q_i  in  ROB_BIT  LSB result tag
cdb_lsb_v_i  in  DAT_W  LSB result value
alu_en_o  out  1  issue valid (to ALU rs_en_i)
alu_op_o  out  OP_W  issued opcode
alu_ic_o  out  1  issued compressed flag
alu_qd_o  out  ROB_BIT  issued destination tag
alu_vs_o  out  DAT_W  issued vs
alu_vt_o  out  DAT_W  issued vt
alu_imm_o  out  DAT_W  issued immediate
alu_pc_o  out  DAT_W  issued PC

Behaviour:
- Reset (rst=0, async): all entry busy bits 0; all alu_* outputs 0; full_o=0.
- en=0: no state change, alu_* outputs hold. The ALU is gated by the same en.
- Per-entry state: busy, op, ic, qd, rs_rdy, qs, vs, rt_rdy, qt, vt, imm, pc. Entry is ready when busy && rs_rdy && rt_rdy.
- full_o is combinational from registered busy bits: 1 iff all RS_SIZE entries are busy.
- Dispatch: on an edge with dsp_en_i=1 and full_o=0, write to the lowest-index non-busy entry. dsp_en_i while full_o=1 is ignored (the dispatcher must not do this).
- Dispatch-time forwarding, per operand: if not rdy and cdb_alu_en_i and cdb_alu_q_i==tag, capture cdb_alu_v_i and set rdy. Else apply the same rule with the LSB bus. If both buses match, ALU wins.
- Wakeup: on every edge, each busy entry with a non-ready operand whose tag matches a valid CDB captures the value and sets rdy. Both operands may wake in the same edge. A single bus may wake many entries.
- Select: from registered state, the lowest-index ready entry. On the edge, copy its fields to alu_* with alu_en_o<=1 and clear its busy bit. If no entry is ready, alu_en_o<=0 and other alu_* outputs hold.
- No same-edge wake-to-issue. An entry woken or dispatched at edge k issues no earlier than edge k+1. Minimum dispatch-to-alu_en_o latency is 2 edges.
- Issue and dispatch on the same edge: the entry freed by issue is not visible to that dispatch, because full_o is computed pre-edge.
- flush_i=1 (synchronous, with en=1): all busy<=0, alu_en_o<=0. It has priority over dispatch, wakeup and issue in that cycle.
- Throughput: one issue per cycle. No starvation guarantee beyond lowest-index priority.
- Width rules: values are stored unmodified. Tags are compared on the full ROB_BIT.

Test Plan:
- Reset then idle: rst low mid-run with 3 busy entries -> alu_en_o=0 immediately; after release, full_o=0 and nothing issues.
- Ready dispatch: ADDI, vs=5, imm=7, both rdy at edge 1 -> edge 2 gives alu_en_o=1, alu_vs_o=5, alu_imm_o=7, alu_qd_o=dsp tag; edge 3 gives alu_en_o=0.
- Wakeup: ADD with qs=3 not ready; cdb_lsb broadcasts q=3, v=0x10 at edge 4 -> issue at edge 5 with alu_vs_o=0x10. The same broadcast at dispatch edge forwards and issues one edge after dispatch.
- Dual bus, same entry: qs=2, qt=6; cdb_alu q=2 v=1 and cdb_lsb q=6 v=9 on the same edge -> next edge issues vs=1, vt=9.
- Full and priority: dispatch 8 ops with no operands ready -> full_o=1, and a 9th dispatch is dropped. Wake entries 5 and 2 together -> entry 2 issues first, entry 5 next cycle, and full_o drops after the first issue.
- Flush and en: flush_i with 4 busy entries and a same-cycle dispatch -> all cleared, alu_en_o=0, dispatch lost. With en=0 during a CDB match -> no capture, outputs frozen.
